// File: rtl/bcd_serial_tx.sv
// Serial BCD digit transmitter: one digit per handshake, sent MSB-first with frame strobe.
// Optional odd parity bit after bit 0 when BCD_TX_PARITY_EN is defined.
module bcd_serial_tx #(
    parameter int GAP = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       linea,
    output logic       frame,
    output logic       busy,
    output logic       err
);

`ifdef BCD_TX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd3
    } state_t;
`endif

    localparam logic [3:0] LP_GAP_LAST = 4'(GAP - 1);

    state_t     r_state, w_state;
    logic [3:0] r_sh, w_sh;
    logic [3:0] r_cnt, w_cnt;
    logic       r_linea, w_linea;
    logic       r_frame, w_frame;
    logic       r_busy, w_busy;
    logic       r_ready, w_ready;
    logic       r_err, w_err;
    logic       w_end;
`ifdef BCD_TX_PARITY_EN
    logic       r_par, w_par;
`endif

    always_comb begin
        w_state = r_state;
        w_sh    = r_sh;
        w_cnt   = r_cnt;
        w_linea = r_linea;
        w_frame = 1'b0;
        w_busy  = r_busy;
        w_ready = r_ready;
        w_err   = 1'b0;
        w_end   = 1'b0;
`ifdef BCD_TX_PARITY_EN
        w_par   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                w_linea = 1'b0;
                if (din_valid && r_ready) begin
                    if (din <= 4'd9) begin
                        // MSB goes out right away; the rest shift from r_sh[3]
                        w_state = S_SHIFT;
                        w_sh    = {din[2:0], 1'b0};
                        w_cnt   = 4'd0;
                        w_linea = din[3];
                        w_frame = 1'b1;
                        w_busy  = 1'b1;
                        w_ready = 1'b0;
`ifdef BCD_TX_PARITY_EN
                        w_par   = ~^din;
`endif
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt != 4'd3) begin
                    w_linea = r_sh[3];
                    w_sh    = {r_sh[2:0], 1'b0};
                    w_cnt   = r_cnt + 4'd1;
                end else begin
`ifdef BCD_TX_PARITY_EN
                    w_state = S_PAR;
                    w_linea = r_par;
`else
                    w_end   = 1'b1;
`endif
                end
            end
`ifdef BCD_TX_PARITY_EN
            S_PAR: begin
                w_end = 1'b1;
            end
`endif
            S_GAP: begin
                if (r_cnt == LP_GAP_LAST) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        if (w_end) begin
            w_linea = 1'b0;
            w_cnt   = 4'd0;
            if (GAP > 0) begin
                w_state = S_GAP;
            end else begin
                w_state = S_IDLE;
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sh    <= 4'd0;
            r_cnt   <= 4'd0;
            r_linea <= 1'b0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
`ifdef BCD_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_sh    <= w_sh;
            r_cnt   <= w_cnt;
            r_linea <= w_linea;
            r_frame <= w_frame;
            r_busy  <= w_busy;
            r_ready <= w_ready;
            r_err   <= w_err;
`ifdef BCD_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign din_ready = r_ready;
    assign linea     = r_linea;
    assign frame     = r_frame;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
